// File: rtl/nic_ctrl.sv
// nic_ctrl: sole master of the NIC register port; round-robin TX arbitration
// over NREQ requesters plus RX drain into a one-entry ready/valid slot.
// Ports: clk, reset (async active-low); req/req_data in, gnt out (TX side);
// rx_valid/rx_data out, rx_ready in (RX side); nic_addr/nic_en/nic_wr_en/
// nic_d_in out, nic_d_out in (NIC register port, read data one cycle late).
module nic_ctrl #(
  parameter int NREQ = 4,
  parameter int DW   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [0:NREQ-1]   req,
  input  logic [0:NREQ*DW-1] req_data,
  output logic [0:NREQ-1]   gnt,
  output logic              rx_valid,
  output logic [0:DW-1]     rx_data,
  input  logic              rx_ready,
  output logic [0:1]        nic_addr,
  output logic              nic_en,
  output logic              nic_wr_en,
  output logic [0:DW-1]     nic_d_in,
  input  logic [0:DW-1]     nic_d_out
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] TX_POLL = 3'd1;
  localparam logic [2:0] TX_CHK  = 3'd2;
  localparam logic [2:0] TX_WR   = 3'd3;
  localparam logic [2:0] RX_POLL = 3'd4;
  localparam logic [2:0] RX_CHK  = 3'd5;
  localparam logic [2:0] RX_RD   = 3'd6;
  localparam logic [2:0] RX_CAP  = 3'd7;

  // pref records the phase served last; the other phase wins a tie
  localparam logic PREF_TX = 1'b0;
  localparam logic PREF_RX = 1'b1;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] rr_q, rr_d;
  logic [PW-1:0] win_q, win_d;
  logic [PW-1:0] win_sel;
  logic          pref_q, pref_d;
  logic          rxv_q, rxv_d;
  logic [0:DW-1] rxd_q, rxd_d;
  logic [0:DW-1] txd_q, txd_d;
  logic          want_rx;
  logic          want_tx;
  logic          st_bit;

  assign want_rx  = !rxv_q;
  assign want_tx  = |req;
  assign st_bit   = nic_d_out[DW-1];
  assign rx_valid = rxv_q;
  assign rx_data  = rxd_q;

  // first requester at or after rr_q, wrapping
  always_comb begin
    logic found;
    int   idx;
    found   = 1'b0;
    win_sel = rr_q;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_sel = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    pref_d  = pref_q;
    rxv_d   = rxv_q;
    rxd_d   = rxd_q;
    txd_d   = txd_q;
    if (rxv_q && rx_ready) rxv_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (want_rx && (!want_tx || pref_q == PREF_TX)) begin
          state_d = RX_POLL;
        end else if (want_tx) begin
          state_d = TX_POLL;
          win_d   = win_sel;
          // flit latched so nic_d_in has no path from inputs
          txd_d   = req_data[int'(win_sel)*DW +: DW];
        end
      end
      TX_POLL: state_d = TX_CHK;
      TX_CHK: begin
        if (st_bit) begin
          state_d = IDLE;
          pref_d  = PREF_TX;
        end else begin
          state_d = TX_WR;
        end
      end
      TX_WR: begin
        rr_d    = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
        pref_d  = PREF_TX;
        state_d = IDLE;
      end
      RX_POLL: state_d = RX_CHK;
      RX_CHK: begin
        pref_d  = PREF_RX;
        state_d = st_bit ? RX_RD : IDLE;
      end
      RX_RD: state_d = RX_CAP;
      RX_CAP: begin
        rxd_d   = nic_d_out;
        rxv_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      win_q   <= '0;
      pref_q  <= PREF_TX;
      rxv_q   <= 1'b0;
      rxd_q   <= '0;
      txd_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      pref_q  <= pref_d;
      rxv_q   <= rxv_d;
      rxd_q   <= rxd_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    gnt       = '0;
    nic_en    = 1'b0;
    nic_wr_en = 1'b0;
    nic_addr  = 2'b00;
    nic_d_in  = '0;
    unique case (state_q)
      TX_POLL: begin
        nic_en   = 1'b1;
        nic_addr = 2'b11;
      end
      TX_WR: begin
        nic_wr_en  = 1'b1;
        nic_d_in   = txd_q;
        gnt[win_q] = 1'b1;
      end
      RX_POLL: begin
        nic_en   = 1'b1;
        nic_addr = 2'b01;
      end
      RX_RD: begin
        nic_en   = 1'b1;
        nic_addr = 2'b00;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nic_ctrl.sv
// tb_nic_ctrl: directed bench for nic_ctrl with a behavioural NIC
// register model (registered read data, programmable output-full polls).
module tb_nic_ctrl;

  localparam int NREQ = 4;
  localparam int DW   = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic [0:NREQ-1]   req;
  logic [0:NREQ*DW-1] req_data;
  logic [0:NREQ-1]   gnt;
  logic              rx_valid;
  logic [0:DW-1]     rx_data;
  logic              rx_ready;
  logic [0:1]        nic_addr;
  logic              nic_en;
  logic              nic_wr_en;
  logic [0:DW-1]     nic_d_in;
  logic [0:DW-1]     nic_d_out;

  nic_ctrl #(.NREQ(NREQ), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .nic_addr  (nic_addr),
    .nic_en    (nic_en),
    .nic_wr_en (nic_wr_en),
    .nic_d_in  (nic_d_in),
    .nic_d_out (nic_d_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic          rx_avail = 1'b0;
  logic [0:DW-1] in_buf   = '0;
  int            full_until = 0;
  logic          mon_on   = 1'b0;

  int en_cnt  = 0;
  int poll11  = 0;
  int gnt_cnt = 0;
  int tx_ev   = 0;
  int rx_ev   = 0;
  int rep     = 0;
  int last_ev = 0;

  // NIC model: read data registered one cycle after nic_en
  always @(posedge clk or negedge reset) begin
    if (!reset) nic_d_out <= '0;
    else if (nic_en) begin
      case (nic_addr)
        2'b00:   nic_d_out <= in_buf;
        2'b01:   nic_d_out <= DW'(rx_avail);
        2'b11:   nic_d_out <= DW'(poll11 < full_until);
        default: nic_d_out <= '0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (nic_en) en_cnt <= en_cnt + 1;
    if (nic_en && nic_addr == 2'b11) poll11 <= poll11 + 1;
    if (|gnt) gnt_cnt <= gnt_cnt + 1;
    if (mon_on) begin
      if (|gnt) begin
        tx_ev <= tx_ev + 1;
        if (last_ev == 1) rep <= rep + 1;
        last_ev <= 1;
      end else if (nic_en && nic_addr == 2'b00) begin
        rx_ev <= rx_ev + 1;
        if (last_ev == 2) rep <= rep + 1;
        last_ev <= 2;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_wr(input int maxc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (nic_wr_en) ok = 1'b1;
    end
    chk("wait_wr", 64'(ok), 64'd1);
  endtask

  initial begin
    logic [0:NREQ-1] e;
    int base;
    reset    = 1'b0;
    req      = '0;
    rx_ready = 1'b0;
    for (int i = 0; i < NREQ; i++)
      req_data[i*DW +: DW] = DW'(64'h1000 + i);
    rx_avail = 1'b1;
    in_buf   = DW'(64'h1234);

    // reset state
    step(3);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_rxv", 64'(rx_valid), 64'd0);
    chk("rst_rxd", 64'(rx_data), 64'd0);
    chk("rst_en", 64'(nic_en), 64'd0);
    chk("rst_wr", 64'(nic_wr_en), 64'd0);
    chk("rst_addr", 64'(nic_addr), 64'd0);
    chk("rst_din", 64'(nic_d_in), 64'd0);

    // RX drain, first service after reset is RX
    reset = 1'b1;
    step(1);
    chk("rx_poll_en", 64'(nic_en), 64'd1);
    chk("rx_poll_addr", 64'(nic_addr), 64'd1);
    step(2);
    chk("rx_rd_en", 64'(nic_en), 64'd1);
    chk("rx_rd_addr", 64'(nic_addr), 64'd0);
    step(1);
    chk("rx_cap_v", 64'(rx_valid), 64'd0);
    step(1);
    chk("rx_v5", 64'(rx_valid), 64'd1);
    chk("rx_d5", 64'(rx_data), 64'h1234);
    rx_avail = 1'b0;
    base = en_cnt;
    step(10);
    chk("rx_hold_nopoll", 64'(en_cnt - base), 64'd0);
    chk("rx_hold_v", 64'(rx_valid), 64'd1);
    chk("rx_hold_d", 64'(rx_data), 64'h1234);

    // round robin, all requesting, output empty
    req = '1;
    for (int g = 0; g < 5; g++) begin
      step(g == 0 ? 3 : 4);
      e = '0;
      e[g % NREQ] = 1'b1;
      chk("rr_gnt", 64'(gnt), 64'(e));
      chk("rr_din", 64'(nic_d_in), 64'h1000 + 64'(g % NREQ));
      if (g == 4) req = '0;
    end
    step(1);
    chk("rr_gnt_off", 64'(gnt), 64'd0);

    // output full for three polls; rr_ptr is 1 so requester 2 wins
    full_until = poll11 + 3;
    base = gnt_cnt;
    req = '0;
    req[2] = 1'b1;
    req[3] = 1'b1;
    step(11);
    chk("full_nognt", 64'(gnt_cnt - base), 64'd0);
    chk("full_polls", 64'(poll11 - (full_until - 3)), 64'd4);
    step(1);
    e = '0;
    e[2] = 1'b1;
    chk("full_gnt", 64'(gnt), 64'(e));
    req[2] = 1'b0;
    step(4);
    e = '0;
    e[3] = 1'b1;
    chk("full_next", 64'(gnt), 64'(e));
    req = '0;
    step(1);

    // single TX with rx slot occupied
    req[1] = 1'b1;
    req_data[1*DW +: DW] = DW'(64'hA5);
    step(2);
    chk("stx_early", 64'(gnt), 64'd0);
    step(1);
    e = '0;
    e[1] = 1'b1;
    chk("stx_gnt", 64'(gnt), 64'(e));
    chk("stx_wr", 64'(nic_wr_en), 64'd1);
    chk("stx_din", 64'(nic_d_in), 64'hA5);
    req = '0;
    step(1);
    chk("stx_wr_off", 64'(nic_wr_en), 64'd0);

    // consumer accepts: slot clears, polling resumes
    rx_ready = 1'b1;
    step(1);
    chk("rx_clr", 64'(rx_valid), 64'd0);
    step(1);
    chk("rx_repoll", 64'({nic_en, nic_addr}), 64'b101);

    // mixed load: phases alternate
    rx_avail = 1'b1;
    in_buf   = DW'(64'h77);
    req[0]   = 1'b1;
    mon_on   = 1'b1;
    step(60);
    mon_on   = 1'b0;
    chk("mix_tx", 64'(tx_ev >= 4), 64'd1);
    chk("mix_rx", 64'(rx_ev >= 4), 64'd1);
    chk("mix_alt", 64'(rep), 64'd0);

    // async reset during TX_WR
    wait_wr(20);
    #1 reset = 1'b0;
    #1;
    chk("ar_gnt", 64'(gnt), 64'd0);
    chk("ar_wr", 64'(nic_wr_en), 64'd0);
    chk("ar_en", 64'(nic_en), 64'd0);
    chk("ar_rxv", 64'(rx_valid), 64'd0);
    rx_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("ar_idle", 64'({nic_en, nic_wr_en, gnt}), 64'd0);
    step(1);
    chk("ar_rxfirst", 64'({nic_en, nic_addr}), 64'b101);
    req = '0;
    step(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nic_ctrl.md
# nic_ctrl

Controller that sequences the cardinal NIC's processor-side register port on behalf of several local requesters. It round-robin arbitrates NREQ transmit requesters onto the NIC output channel, polling the output status before every write. It also polls the input channel status and drains received flits into a one-entry ready/valid receive slot. It sits between the core-side agents and the NIC's addr/d_in/d_out/nicEn/nicWrEn port, and is the only master of that port.

## Interface
- NREQ, 4, number of transmit requesters (2..8)
- DW, 64, flit width; bit 0 is MSB, bit DW-1 is LSB
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state when 0
- req  in  [0:NREQ-1]  transmit request per requester; held with data until its gnt
- req_data  in  [0:NREQ*DW-1]  requester i flit at bits [i*DW : i*DW+DW-1]
- gnt  out  [0:NREQ-1]  one-cycle pulse; flit of that requester written to the NIC this cycle
- rx_valid  out  1  receive slot holds a flit
- rx_data  out  [0:DW-1]  received flit, stable while rx_valid
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready at a clock edge
- nic_addr  out  [0:1]  NIC register address
- nic_en  out  1  NIC register read enable
- nic_wr_en  out  1  NIC output-buffer write enable
- nic_d_in  out  [0:DW-1]  flit to the NIC
- nic_d_out  in  [0:DW-1]  NIC read data, registered: valid the cycle after the nic_en cycle

## Operation
- NIC map: 00 = read input buffer (clears input status); 01 = input status (bit DW-1); 11 = output status (bit DW-1, 1 = full); nic_wr_en loads the output buffer.
- States: IDLE, TX_POLL, TX_CHK, TX_WR, RX_POLL, RX_CHK, RX_RD, RX_CAP. Only one NIC transaction is in flight at a time.
- IDLE:
  - want_rx = !rx_valid; want_tx = |req.
  - If both are set, pick the phase opposite to pref. pref = 0 after reset, so RX is served first. Otherwise take whichever is set; stay in IDLE if neither.
  - Entering TX_POLL latches winner: the first i with req[i], searching from rr_ptr upward with wrap.
- TX_POLL: nic_en=1, nic_addr=11 -> TX_CHK.
- TX_CHK: if nic_d_out[DW-1]=1 (full), go to IDLE with pref=TX and rr_ptr unchanged; otherwise go to TX_WR.
- TX_WR:
  - nic_wr_en=1; nic_d_in = winner's data; gnt[winner]=1.
  - rr_ptr <= (winner+1) mod NREQ; pref <= TX -> IDLE.
- RX_POLL: nic_en=1, nic_addr=01 -> RX_CHK.
- RX_CHK: if nic_d_out[DW-1]=1, go to RX_RD; otherwise go to IDLE. In both cases pref <= RX.
- RX_RD: nic_en=1, nic_addr=00 -> RX_CAP.
- RX_CAP: rx_data <= nic_d_out; rx_valid <= 1 -> IDLE.
- rx_valid clears on the edge where rx_valid && rx_ready. RX polling never starts while rx_valid=1.
- nic_en, nic_wr_en, nic_addr, nic_d_in and gnt decode from the state and winner registers only. No input-to-output combinational path exists.
- nic_d_in = 0 and nic_addr = 00 outside the states that drive them.

## Timing
- Reset values: state IDLE, rr_ptr 0, winner 0, pref 0.
- Reset values of outputs: gnt, rx_valid, rx_data, nic_en, nic_wr_en, nic_addr and nic_d_in all 0.
- TX path, IDLE at cycle 0 choosing TX:
  - cycle 1 TX_POLL, cycle 2 TX_CHK, cycle 3 TX_WR with gnt pulse.
  - NIC output status reads full from cycle 4.
  - Minimum spacing between successive gnts is 4 cycles.
- RX path, IDLE at cycle 0 choosing RX: RX_POLL at cycle 1, RX_RD at cycle 3, RX_CAP at cycle 4, rx_valid=1 from cycle 5.
- A req that drops before its gnt is a protocol violation. Behaviour is undefined, but the FSM must still return to IDLE.
- A reset assertion in any state forces IDLE and all outputs to 0 immediately. A flit consumed by RX_RD but not yet captured is lost; the NIC is reset alongside.
- A full NIC output channel causes repeated TX_POLL/TX_CHK cycles interleaved with RX service. There is no gnt until status reads 0.

## Test plan
- Reset check: hold reset=0 mid TX_WR -> gnt, nic_wr_en, nic_en and rx_valid read 0 asynchronously; state is IDLE after release.
- Single TX: req=4'b0010, data 64'hA5, NIC empty, rx_valid held 1 -> gnt[1] pulses 3 cycles after IDLE; nic_wr_en=1 with nic_d_in=64'hA5 in that cycle.
- Round robin: req=4'b1111 held, NIC always empty, no RX -> gnt order 0,1,2,3,0, spaced 4 cycles apart.
- Full output: output status stays 1 for 3 polls, then 0 -> no gnt during the full polls; the same winner is granted afterwards and rr_ptr is unchanged meanwhile.
- RX drain: NIC input holds 64'h1234 with rx_ready=0 -> rx_valid=1 and rx_data=64'h1234 at cycle 5; no further RX polls until rx_ready=1 clears rx_valid.
- Mixed load: req[0] held and RX traffic continuous -> TX and RX phases alternate; no starvation of either.
